// File: rtl/mux8_rr_arbiter_if.sv
// Bus between requester logic and the mux8_rr_arbiter.
//   en           arbitration enable; only blocks new grants
//   req          request vector, one bit per requester
//   grant        one-hot grant, registered; zero when idle
//   sel          mux select, registered; drives mux8to1 s[2:0]
//   busy         high while a grant is active
//   hold_expired single-cycle pulse on a forced release
// master: requester side, slave: arbiter side.
interface mux8_rr_arbiter_if #(
  parameter int SELW = 3
);
  localparam int NREQ = 1 << SELW;

  logic            en;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic [SELW-1:0] sel;
  logic            busy;
  logic            hold_expired;

  modport master (output en, req, input grant, sel, busy, hold_expired);
  modport slave  (input en, req, output grant, sel, busy, hold_expired);
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter and select sequencer for the shared 8:1 mux path.
// One requester is granted at a time. The grant is held until that requester drops
// its req. The mux select is registered alongside the grant.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  mux8_rr_arbiter_if.slave (en, req in; grant, sel, busy, hold_expired out)
// Optional feature: define MUXARB_TIMEOUT_EN to force a release after MAX_HOLD
// visible grant cycles. hold_expired then pulses for one cycle on that release.
module mux8_rr_arbiter #(
  parameter int SELW     = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  mux8_rr_arbiter_if.slave  bus
);
  localparam int NREQ = 1 << SELW;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [SELW-1:0] win, idx;
  logic            found;
  logic            expire_w;
  logic            hx_d;

  // Search upward from the slot after the last winner. Offset NREQ wraps back to
  // ptr itself, so the last-granted requester is considered last.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = ptr_q + SELW'(i);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

`ifdef MUXARB_TIMEOUT_EN
  localparam int HOLDW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [HOLDW-1:0] hold_q, hold_d;
  logic             hx_q;

  // hold_q counts the GRANT edges passed since entry, which is one less than the
  // number of cycles the grant has been visible.
  assign expire_w = (state_q == GRANT) && (hold_q == HOLDW'(MAX_HOLD - 1));
  assign hold_d   = (state_q == GRANT) ? hold_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      hx_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      hx_q   <= hx_d;
    end
  end

  assign bus.hold_expired = hx_q;
`else
  assign expire_w         = 1'b0;
  assign bus.hold_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    hx_d    = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (bus.en && found) begin
          grant_d = NREQ'(1) << win;
          sel_d   = win;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // en is not looked at here. Only the owner's req, or the timeout, ends the grant.
        if (!bus.req[sel_q] || expire_w) begin
          grant_d = '0;
          ptr_d   = sel_q;
          state_d = IDLE;
          hx_d    = expire_w && bus.req[sel_q];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '1;
      sel_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.busy  = |grant_q;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;
  localparam int MAXH = 4;
`ifdef MUXARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mux8_rr_arbiter_if #(.SELW(3)) bus ();
  mux8_rr_arbiter #(.SELW(3), .MAX_HOLD(MAXH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: who owns the mux, how long it has been visible, last winner.
  bit m_busy;
  int m_sel, m_ptr, m_vis;
  bit m_hx;

  function automatic void model_step(bit r, bit e, logic [7:0] q);
    if (r) begin
      m_busy = 0; m_sel = 0; m_ptr = 7; m_vis = 0; m_hx = 0;
    end else if (!m_busy) begin
      m_hx = 0;
      if (e && q != 0) begin
        for (int i = 1; i <= 8; i++)
          if (q[(m_ptr + i) % 8]) begin m_sel = (m_ptr + i) % 8; break; end
        m_busy = 1; m_vis = 1;
      end
    end else if (!q[m_sel]) begin
      m_busy = 0; m_ptr = m_sel; m_hx = 0;
    end else if (TMO && m_vis == MAXH) begin
      m_busy = 0; m_ptr = m_sel; m_hx = 1;
    end else begin
      m_vis++; m_hx = 0;
    end
  endfunction

  function automatic logic [7:0] m_grant();
    return m_busy ? (8'h01 << m_sel) : 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(rst, bus.en, bus.req);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b1; bus.req = 8'h00;
    tick();
    checks++;
    if (bus.grant !== 8'h00 || bus.sel !== 3'd0 || bus.busy !== 1'b0 || bus.hold_expired !== 1'b0) begin
      errors++; $display("FAIL reset_state grant=%h sel=%0d busy=%b hx=%b exp 00/0/0/0", bus.grant, bus.sel, bus.busy, bus.hold_expired);
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (bus.grant !== 8'h00 || bus.sel !== 3'd0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL reset_idle c%0d grant=%h sel=%0d busy=%b exp 00/0/0", c, bus.grant, bus.sel, bus.busy);
      end
    end
  endtask

  task automatic test_two_req();
    do_reset();
    bus.en = 1'b1; bus.req = 8'h81;
    tick();
    checks++;
    if (bus.grant !== 8'h01 || bus.sel !== 3'd0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL two_first grant=%h sel=%0d busy=%b exp 01/0/1", bus.grant, bus.sel, bus.busy);
    end
    tick();
    checks++;
    if (bus.grant !== 8'h01) begin errors++; $display("FAIL two_hold grant=%h exp 01", bus.grant); end
    bus.req = 8'h80;
    tick();
    checks++;
    if (bus.grant !== 8'h00 || bus.busy !== 1'b0 || bus.sel !== 3'd0) begin
      errors++; $display("FAIL two_gap grant=%h busy=%b sel=%0d exp 00/0/0", bus.grant, bus.busy, bus.sel);
    end
    tick();
    checks++;
    if (bus.grant !== 8'h80 || bus.sel !== 3'd7) begin
      errors++; $display("FAIL two_second grant=%h sel=%0d exp 80/7", bus.grant, bus.sel);
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_rotate();
    do_reset();
    bus.en = 1'b1; bus.req = 8'hFF;
    for (int j = 0; j < 9; j++) begin
      int exp_k;
      logic [7:0] eg;
      exp_k = j % 8;
      eg = 8'h01 << exp_k;
      tick();
      checks++;
      if (bus.grant !== eg || bus.sel !== 3'(exp_k)) begin
        errors++; $display("FAIL rotate_grant j%0d grant=%h sel=%0d exp %h/%0d", j, bus.grant, bus.sel, eg, exp_k);
      end
      bus.req = 8'hFF & ~eg;
      tick();
      checks++;
      if (bus.grant !== 8'h00 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL rotate_gap j%0d grant=%h busy=%b exp 00/0", j, bus.grant, bus.busy);
      end
      bus.req = 8'hFF;
    end
    bus.req = 8'h00;
    tick(); tick();
  endtask

  task automatic test_enable();
    do_reset();
    bus.en = 1'b0; bus.req = 8'h10;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bus.grant !== 8'h00) begin errors++; $display("FAIL en_off c%0d grant=%h exp 00", c, bus.grant); end
    end
    bus.en = 1'b1;
    tick();
    checks++;
    if (bus.grant !== 8'h10 || bus.sel !== 3'd4) begin
      errors++; $display("FAIL en_on grant=%h sel=%0d exp 10/4", bus.grant, bus.sel);
    end
    // en low during a grant must not drop it
    bus.en = 1'b0;
    tick();
    checks++;
    if (bus.grant !== 8'h10) begin errors++; $display("FAIL en_mid_grant grant=%h exp 10", bus.grant); end
    bus.en = 1'b1; bus.req = 8'h00;
    tick();
  endtask

  task automatic test_hold();
    logic [7:0] eg;
    logic       eh;
    do_reset();
    bus.en = 1'b1; bus.req = 8'h03;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (TMO) begin
        // Period of 5: four visible cycles of one owner, then one gap with a pulse.
        eg = (c % 5 == 4) ? 8'h00 : (((c / 5) % 2 == 0) ? 8'h01 : 8'h02);
        eh = (c % 5 == 4);
      end else begin
        eg = 8'h01; eh = 1'b0;
      end
      checks++;
      if (bus.grant !== eg || bus.hold_expired !== eh) begin
        errors++; $display("FAIL hold c%0d grant=%h hx=%b exp %h/%b", c, bus.grant, bus.hold_expired, eg, eh);
      end
    end
    bus.req = 8'h00;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.en = 1'b1; bus.req = 8'h20;
    tick();
    checks++;
    if (bus.grant !== 8'h20 || bus.sel !== 3'd5) begin
      errors++; $display("FAIL rstmid_pre grant=%h sel=%0d exp 20/5", bus.grant, bus.sel);
    end
    bus.req = 8'h21; rst = 1'b1;
    tick();
    checks++;
    if (bus.grant !== 8'h00 || bus.sel !== 3'd0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_drop grant=%h sel=%0d busy=%b exp 00/0/0", bus.grant, bus.sel, bus.busy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.grant !== 8'h01 || bus.sel !== 3'd0) begin
      errors++; $display("FAIL rstmid_after grant=%h sel=%0d exp 01/0", bus.grant, bus.sel);
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.en  = ($urandom_range(9) != 0);
      bus.req = 8'($urandom) & 8'($urandom);
      rst     = ($urandom_range(49) == 0);
      tick();
      checks++;
      if (bus.grant !== m_grant() || bus.sel !== 3'(m_sel) || bus.busy !== m_busy || bus.hold_expired !== m_hx) begin
        errors++;
        $display("FAIL random c%0d grant=%h sel=%0d busy=%b hx=%b exp %h/%0d/%b/%b",
                 c, bus.grant, bus.sel, bus.busy, bus.hold_expired, m_grant(), m_sel, m_busy, m_hx);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0; bus.req = 8'h00;
    m_busy = 0; m_sel = 0; m_ptr = 7; m_vis = 0; m_hx = 0;
    @(negedge clk);
    test_reset();
    test_two_req();
    test_rotate();
    test_enable();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
